// File: rtl/mant_align_shifter.sv
// Serial mantissa alignment for FP add/sub: right-shifts the smaller-exponent mantissa one bit per clock.
// Optional feature: define MANT_ALIGN_STICKY_EN to accumulate the sticky bit (otherwise sticky is tied low).
module mant_align_shifter #(
   parameter int EW = 5,
   parameter int MW = 11
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [EW-1:0]   diff,
   input  logic            a_ge_b,
   input  logic [EW-1:0]   exp_a,
   input  logic [EW-1:0]   exp_b,
   input  logic [MW-1:0]   man_a,
   input  logic [MW-1:0]   man_b,
   output logic            busy,
   output logic            done,
   output logic [EW-1:0]   exp_out,
   output logic [MW-1:0]   man_big,
   output logic [MW+1:0]   man_small,
   output logic            sticky
);

   localparam int SW = MW + 2;
   localparam int CW = $clog2(SW + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [EW-1:0]   exp_q, exp_d;
   logic [MW-1:0]   big_q, big_d;
   logic [SW-1:0]   small_q, small_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [CW-1:0]   count_sat_s;

   // Distances beyond the full {mantissa,guard,round} width all flush to zero.
   always_comb begin
      if ({{(32-EW){1'b0}}, diff} >= 32'(SW)) begin
         count_sat_s = CW'(SW);
      end else begin
         count_sat_s = CW'(diff);
      end
   end

`ifdef MANT_ALIGN_STICKY_EN
   logic sticky_q, sticky_d;
`endif

   // Next-state, datapath update and registered handshake outputs.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      exp_d   = exp_q;
      big_d   = big_q;
      small_d = small_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
`ifdef MANT_ALIGN_STICKY_EN
      sticky_d = sticky_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               exp_d   = a_ge_b ? exp_a : exp_b;
               big_d   = a_ge_b ? man_a : man_b;
               small_d = {(a_ge_b ? man_b : man_a), 2'b00};
               count_d = count_sat_s;
`ifdef MANT_ALIGN_STICKY_EN
               sticky_d = 1'b0;
`endif
               if (count_sat_s == CW'(0)) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = SHIFT;
                  busy_d  = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            small_d = small_q >> 1;
            count_d = count_q - CW'(1);
`ifdef MANT_ALIGN_STICKY_EN
            sticky_d = sticky_q | small_q[0];
`endif
            if (count_q == CW'(1)) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               state_d = SHIFT;
               busy_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         exp_q   <= '0;
         big_q   <= '0;
         small_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         exp_q   <= exp_d;
         big_q   <= big_d;
         small_q <= small_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef MANT_ALIGN_STICKY_EN
   // Sticky accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end
   assign sticky = sticky_q;
`else
   assign sticky = 1'b0;
`endif

   assign busy      = busy_q;
   assign done      = done_q;
   assign exp_out   = exp_q;
   assign man_big   = big_q;
   assign man_small = small_q;

endmodule
